// File: rtl/clkdiv_frac_multi_if.sv
// Control/status bundle for the multi-channel fractional clock-enable generator.
// The master drives enables and divisors; the slave (the divider) returns ticks and status.
interface clkdiv_frac_multi_if #(
    parameter int N_CH   = 4,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
);
    logic [N_CH-1:0]        en;
    logic [N_CH*INT_W-1:0]  div_int;
    logic [N_CH*FRAC_W-1:0] div_frac;
    logic                   phase_sync;
    logic [N_CH-1:0]        tick;
    logic [N_CH-1:0]        tick_nrz;
    logic [N_CH-1:0]        running;

    modport master (
        output en, div_int, div_frac, phase_sync,
        input  tick, tick_nrz, running
    );

    modport slave (
        input  en, div_int, div_frac, phase_sync,
        output tick, tick_nrz, running
    );
endinterface

// File: rtl/clkdiv_frac_multi.sv
// N independent integer.fractional clock-enable dividers sharing one reset and phase_sync.
// Each channel emits a one-cycle tick per period plus an NRZ copy that toggles per tick.
module clkdiv_frac_multi #(
    parameter int N_CH   = 4,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    clkdiv_frac_multi_if.slave  bus
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [INT_W-1:0]  w_div_int;
        logic [FRAC_W-1:0] w_div_frac;
        logic [INT_W:0]    w_int_eff;
        logic [FRAC_W:0]   w_sum;
        logic [INT_W:0]    r_ctr;
        logic [FRAC_W-1:0] r_acc;
        logic              r_running;
        logic              r_tick;
        logic              r_tick_nrz;

        assign w_div_int  = bus.div_int[g*INT_W +: INT_W];
        assign w_div_frac = bus.div_frac[g*FRAC_W +: FRAC_W];
        // A zero integer divisor behaves as divide-by-one.
        assign w_int_eff  = (w_div_int == '0) ? (INT_W+1)'(1) : {1'b0, w_div_int};
        // Carry out of the fractional accumulator stretches the next period by one cycle.
        assign w_sum      = {1'b0, r_acc} + {1'b0, w_div_frac};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ctr      <= '0;
                r_acc      <= '0;
                r_running  <= 1'b0;
                r_tick     <= 1'b0;
                r_tick_nrz <= 1'b0;
            end else if (!bus.en[g]) begin
                r_ctr     <= '0;
                r_acc     <= '0;
                r_running <= 1'b0;
                r_tick    <= 1'b0;
            end else if (bus.phase_sync || !r_running) begin
                r_ctr     <= w_int_eff;
                r_acc     <= '0;
                r_running <= 1'b1;
                r_tick    <= 1'b0;
            end else if (r_ctr == (INT_W+1)'(1)) begin
                r_acc      <= w_sum[FRAC_W-1:0];
                r_ctr      <= w_int_eff + (INT_W+1)'(w_sum[FRAC_W]);
                r_tick     <= 1'b1;
                r_tick_nrz <= ~r_tick_nrz;
            end else begin
                r_ctr  <= r_ctr - (INT_W+1)'(1);
                r_tick <= 1'b0;
            end
        end

        assign bus.tick[g]     = r_tick;
        assign bus.tick_nrz[g] = r_tick_nrz;
        assign bus.running[g]  = r_running;
    end
endmodule
